inv_adder_solve_ctrl: RTL and testbench

Sequencer wrapped around the annealed invertible ripple adder (adder core plus annealer). It accepts one solve request through a valid/ready handshake and drives the adder's mode, update_mode and clamped operands. It pulses the adder reset to restart annealing, waits a burn-in period, then counts how often each output bit is 1 over a sample window. It returns the majority-voted a/b/sum/overflow as the solution, which replaces the manual per-bit averaging done in simulation.

---
 rtl/inv_adder_pkg.sv | 20 ++
 rtl/bit_vote_counter.sv | 30 +++
 rtl/inv_adder_solve_ctrl.sv | 147 ++++++++++++++
 tb/tb_inv_adder_solve_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_adder_pkg.sv
// Shared types and defaults for the invertible-adder solve controller.
package inv_adder_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;

    localparam logic [1:0] MODE_FWD     = 2'd0;
    localparam logic [1:0] MODE_INV_SUM = 2'd1;
    localparam logic [1:0] MODE_SUB     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BURN,
        ST_SAMPLE,
        ST_VOTE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bit_vote_counter.sv
// Counts how many sampled cycles a single adder output bit was 1 and
// reports whether that bit won a strict majority of the sample window.
module bit_vote_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    input  logic [CNT_W-1:0] window,
    output logic             vote
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && bit_in) begin
            count <= count + CNT_W'(1);
        end
    end

    // 2*count > window, one extra bit so the doubling cannot wrap; a tie votes 0
    assign vote = {count, 1'b0} > {1'b0, window};

endmodule

// File: rtl/inv_adder_solve_ctrl.sv
// Solve sequencer for the annealed invertible adder: restart, burn-in,
// sample window, then a per-bit majority vote returned as the solution.
module inv_adder_solve_ctrl
    import inv_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic             req_update_mode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_sum,
    input  logic [CNT_W-1:0] req_burn_in,
    input  logic [CNT_W-1:0] req_window,
    input  logic             abort,
    output logic             adder_reset,
    output logic [1:0]       adder_mode,
    output logic             adder_update_mode,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic [WIDTH-1:0] adder_sum,
    input  logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_out,
    input  logic             overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_overflow,
    output logic             busy,
    output state_t           state
);

    // Both handshakes are plain valid/ready: a transfer happens on a rising
    // clock edge where valid and ready are both high, and nothing else moves.

    localparam int NBITS = 3 * WIDTH + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burn_q, win_q, cnt_q;
    logic [NBITS-1:0] sample_bits, votes;
    logic             cnt_clear, cnt_en;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        res_valid = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_clear = 1'b1;
                if (abort)              state_d = ST_IDLE;
                else if (burn_q != '0)  state_d = ST_BURN;
                else                    state_d = ST_SAMPLE;
            end
            ST_BURN: begin
                if (abort)                     state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(1))   state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                cnt_en = 1'b1;
                if (abort)                     state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(1))   state_d = ST_VOTE;
            end
            ST_VOTE: state_d = ST_DONE;
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adder_reset       <= 1'b1;
            adder_mode        <= 2'd0;
            adder_update_mode <= 1'b0;
            adder_a           <= '0;
            adder_b           <= '0;
            adder_sum         <= '0;
            burn_q            <= '0;
            win_q             <= '0;
            cnt_q             <= '0;
            res_a             <= '0;
            res_b             <= '0;
            res_sum           <= '0;
            res_overflow      <= 1'b0;
        end else begin
            // registered so the adder sees a clean reset pulse aligned to CLEAR
            adder_reset <= (state_d == ST_CLEAR);
            if (state_q == ST_IDLE && req_valid) begin
                adder_mode        <= req_mode;
                adder_update_mode <= req_update_mode;
                adder_a           <= req_a;
                adder_b           <= req_b;
                adder_sum         <= req_sum;
                burn_q            <= req_burn_in;
                win_q             <= (req_window == '0) ? CNT_W'(1) : req_window;
            end
            // one down-counter serves both the burn-in and the sample window
            if (state_d == ST_BURN && state_q != ST_BURN)
                cnt_q <= burn_q;
            else if (state_d == ST_SAMPLE && state_q != ST_SAMPLE)
                cnt_q <= win_q;
            else if (state_q == ST_BURN || state_q == ST_SAMPLE)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == ST_VOTE)
                {res_overflow, res_sum, res_b, res_a} <= votes;
        end
    end

    assign sample_bits = {overflow, sum_out, b_out, a_out};

    for (genvar i = 0; i < NBITS; i++) begin : g_vote
        bit_vote_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (reset),
            .clear  (cnt_clear),
            .en     (cnt_en),
            .bit_in (sample_bits[i]),
            .window (win_q),
            .vote   (votes[i])
        );
    end

    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_inv_adder_solve_ctrl.sv
// Directed bench for inv_adder_solve_ctrl driving a behavioural mock adder.
module tb_inv_adder_solve_ctrl;
    import inv_adder_pkg::*;

    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_mode = 2'd0;
    logic          req_update_mode = 1'b0;
    logic [W-1:0]  req_a = '0, req_b = '0, req_sum = '0;
    logic [CW-1:0] req_burn_in = '0, req_window = '0;
    logic          abort = 1'b0;
    logic          adder_reset;
    logic [1:0]    adder_mode;
    logic          adder_update_mode;
    logic [W-1:0]  adder_a, adder_b, adder_sum;
    logic [W-1:0]  a_out, b_out, sum_out;
    logic          overflow;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_a, res_b, res_sum;
    logic          res_overflow;
    logic          busy;
    state_t        state;

    logic          force_en = 1'b0;
    logic [W-1:0]  force_sum = '0;
    logic [15:0]   pat = '0;

    int n_checks = 0;
    int n_pass = 0;
    int lat, rst_cyc, vs;

    always #5 clk = ~clk;

    inv_adder_solve_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_update_mode(req_update_mode),
        .req_a(req_a), .req_b(req_b), .req_sum(req_sum),
        .req_burn_in(req_burn_in), .req_window(req_window),
        .abort(abort), .adder_reset(adder_reset),
        .adder_mode(adder_mode), .adder_update_mode(adder_update_mode),
        .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
        .a_out(a_out), .b_out(b_out), .sum_out(sum_out), .overflow(overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_a(res_a), .res_b(res_b), .res_sum(res_sum), .res_overflow(res_overflow),
        .busy(busy), .state(state)
    );

    // Mock adder: settles instantly on the exact answer for each mode
    always_comb begin
        a_out    = adder_a;
        b_out    = adder_b;
        sum_out  = adder_sum;
        overflow = 1'b0;
        case (adder_mode)
            MODE_FWD:               {overflow, sum_out} = {1'b0, adder_a} + {1'b0, adder_b};
            MODE_INV_SUM, MODE_SUB: b_out = adder_sum - adder_a;
            default: ;
        endcase
        if (force_en) sum_out = force_sum;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Cycle 0 is the cycle whose closing edge accepts the request.
    task automatic run_solve(input logic [1:0] mode, input logic upd,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] s, input logic [CW-1:0] burn,
                             input logic [CW-1:0] win, input int abort_at,
                             output int lat_o, output int rst_o);
        int  smp;
        bit  aborted;
        lat_o = -1;
        rst_o = 0;
        smp = 0;
        aborted = 0;
        @(negedge clk);
        req_mode = mode; req_update_mode = upd;
        req_a = a; req_b = b; req_sum = s;
        req_burn_in = burn; req_window = win;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (adder_reset) rst_o++;
            if (res_valid) begin
                lat_o = cyc;
                break;
            end
            if (aborted && state == ST_IDLE) break;
            if (state == ST_SAMPLE) begin
                force_sum = pat[smp] ? 4'd1 : 4'd0;
                abort = (smp == abort_at);
                if (smp == abort_at) aborted = 1;
                smp++;
            end else begin
                abort = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic finish_done();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_adder_reset", adder_reset, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_adder_mode", adder_mode, 0);
        check("rst_adder_a", adder_a, 0);
        check("rst_res_sum", res_sum, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_adder_reset", adder_reset, 0);

        // 1. Forward solve, 1 + 7
        run_solve(MODE_FWD, 1'b1, 4'd1, 4'd7, 4'd0, 16'd8, 16'd100, -1, lat, rst_cyc);
        check("fwd_latency", lat, 111);
        check("fwd_adder_reset_cycles", rst_cyc, 1);
        check("fwd_res_sum", res_sum, 8);
        check("fwd_res_overflow", res_overflow, 0);
        check("fwd_res_a", res_a, 1);
        check("fwd_res_b", res_b, 7);
        check("fwd_update_mode", adder_update_mode, 1);
        finish_done();
        check("fwd_back_idle", state, ST_IDLE);
        check("fwd_hold_a", adder_a, 1);
        check("fwd_hold_b", adder_b, 7);

        // 2. Tie vote on sum bit 0
        force_en = 1'b1;
        pat = 16'b0011;
        run_solve(MODE_FWD, 1'b0, 4'd0, 4'd0, 4'd0, 16'd0, 16'd4, -1, lat, rst_cyc);
        check("tie_latency", lat, 7);
        check("tie_res_sum", res_sum, 0);
        finish_done();
        pat = 16'b0111;
        run_solve(MODE_FWD, 1'b0, 4'd0, 4'd0, 4'd0, 16'd0, 16'd4, -1, lat, rst_cyc);
        check("maj_latency", lat, 7);
        check("maj_res_sum", res_sum, 1);
        finish_done();
        force_en = 1'b0;
        pat = '0;

        // 3. Zero window behaves as a one-cycle window
        run_solve(MODE_FWD, 1'b0, 4'd5, 4'd7, 4'd0, 16'd0, 16'd0, -1, lat, rst_cyc);
        check("zw_latency", lat, 4);
        check("zw_res_sum", res_sum, 12);
        check("zw_res_overflow", res_overflow, 0);
        finish_done();

        // 4. Backpressure in DONE, then a pending request is taken from IDLE
        run_solve(MODE_FWD, 1'b0, 4'd2, 4'd3, 4'd0, 16'd1, 16'd2, -1, lat, rst_cyc);
        check("bp_latency", lat, 6);
        check("bp_res_sum", res_sum, 5);
        req_a = 4'd9; req_b = 4'd4; req_burn_in = 16'd0; req_window = 16'd1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_sum", res_sum, 5);
            check("bp_req_ready", req_ready, 0);
            check("bp_not_accepted", adder_a, 2);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_idle", state, ST_IDLE);
        check("bp_idle_valid", res_valid, 0);
        check("bp_idle_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_accepted_state", state, ST_CLEAR);
        check("bp_accepted_a", adder_a, 9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("clear_abort_idle", state, ST_IDLE);

        // 5. Abort on the 10th sample cycle, then a normal subtract solve
        run_solve(MODE_SUB, 1'b0, 4'd3, 4'd0, 4'd12, 16'd5, 16'd50, 9, lat, rst_cyc);
        check("abort_no_result", lat, -1);
        check("abort_idle", state, ST_IDLE);
        check("abort_busy", busy, 0);
        vs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) vs++;
        end
        check("abort_valid_quiet", vs, 0);
        run_solve(MODE_SUB, 1'b0, 4'd3, 4'd0, 4'd12, 16'd2, 16'd20, -1, lat, rst_cyc);
        check("sub_latency", lat, 25);
        check("sub_res_b", res_b, 9);
        check("sub_res_a", res_a, 3);
        check("sub_res_sum", res_sum, 12);
        finish_done();

        // 6. Asynchronous reset in the middle of burn-in
        @(negedge clk);
        req_mode = MODE_FWD; req_a = 4'd6; req_b = 4'd6;
        req_burn_in = 16'd50; req_window = 16'd10;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("pre_reset_burn", state, ST_BURN);
        check("pre_reset_adder_reset", adder_reset, 0);
        #2 reset = 1'b1;
        #1;
        check("async_adder_reset", adder_reset, 1);
        check("async_busy", busy, 0);
        check("async_res_valid", res_valid, 0);
        check("async_adder_a", adder_a, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);
        run_solve(MODE_FWD, 1'b0, 4'd2, 4'd3, 4'd0, 16'd0, 16'd3, -1, lat, rst_cyc);
        check("post_reset_latency", lat, 6);
        check("post_reset_sum", res_sum, 5);
        finish_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
